// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - funct3 size codes, responder FSM state and byte-enable types
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, DONE} dmem_state_t;

  typedef logic [3:0] byte_en_t;

  // Unsigned variants exist only for loads.
  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    if (is_load) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                        (f3 == F3_BU) || (f3 == F3_HU);
    else         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/dmem_lane_ctrl.sv
// rtl/dmem_lane_ctrl.sv - byte-lane steering, load extension and alignment check
module dmem_lane_ctrl
  import riscv_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] raw_word,
  output byte_en_t    byte_en,
  output logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    case (offset)
      2'd0:    lane_byte = raw_word[7:0];
      2'd1:    lane_byte = raw_word[15:8];
      2'd2:    lane_byte = raw_word[23:16];
      default: lane_byte = raw_word[31:24];
    endcase
    lane_half = offset[1] ? raw_word[31:16] : raw_word[15:0];
  end

  always_comb begin
    byte_en    = 4'b1111;
    store_data = wdata;
    load_data  = raw_word;
    misalign   = 1'b0;
    case (func3[1:0])
      2'b00: begin
        byte_en    = 4'b0001 << offset;
        store_data = {4{wdata[7:0]}};
        load_data  = func3[2] ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      end
      2'b01: begin
        byte_en    = offset[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata[15:0]}};
        load_data  = func3[2] ? {16'd0, lane_half} : {{16{lane_half[15]}}, lane_half};
        misalign   = offset[0];
      end
      default: begin
        misalign = |offset;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated data memory responder for the core load/store path
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYC    = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ls_req,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        stall
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dmem_state_t state;
  logic [3:0]  cnt;
  logic        lat_read, lat_write;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr, lat_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  // In IDLE the live inputs stand in for the latch so a zero-wait request
  // can be judged on the same edge it is accepted.
  logic        cur_read, cur_write;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr, cur_wdata;

  assign cur_read  = (state == IDLE) ? mem_read  : lat_read;
  assign cur_write = (state == IDLE) ? mem_write : lat_write;
  assign cur_f3    = (state == IDLE) ? func3     : lat_f3;
  assign cur_addr  = (state == IDLE) ? addr      : lat_addr;
  assign cur_wdata = (state == IDLE) ? wdata     : lat_wdata;

  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             out_of_range;
  logic [31:0]      raw_word;

  assign offset       = cur_addr - BASE_ADDR;
  assign idx          = offset[IDX_W+1:2];
  assign out_of_range = |offset[31:IDX_W+2];
  assign raw_word     = mem[idx];

  byte_en_t    byte_en;
  logic [31:0] store_data, load_data;
  logic        misalign;

  dmem_lane_ctrl u_lane (
    .func3      (cur_f3),
    .offset     (offset[1:0]),
    .wdata      (cur_wdata),
    .raw_word   (raw_word),
    .byte_en    (byte_en),
    .store_data (store_data),
    .load_data  (load_data),
    .misalign   (misalign)
  );

  logic illegal;
  assign illegal = (cur_read == cur_write) || !f3_legal(cur_read, cur_f3) ||
                   misalign || out_of_range;

  assign stall = ls_req && !ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rdata     <= 32'd0;
      ready     <= 1'b0;
      err       <= 1'b0;
      lat_read  <= 1'b0;
      lat_write <= 1'b0;
      lat_f3    <= 3'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ls_req) begin
            lat_read  <= mem_read;
            lat_write <= mem_write;
            lat_f3    <= func3;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            cnt       <= 4'(WAIT_CYC);
            if (WAIT_CYC == 0) begin
              state <= ACK;
              ready <= 1'b1;
              err   <= illegal;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= ACK;
            ready <= 1'b1;
            err   <= illegal;
          end
        end
        ACK: begin
          if (!illegal && lat_read) rdata <= load_data;
          ready <= 1'b0;
          err   <= 1'b0;
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Array is deliberately unreset; gating on rst_n drops a store racing reset.
  always_ff @(posedge clk) begin
    if (rst_n && state == ACK && !illegal && lat_write) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed table-driven bench for dmem_responder
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ls_req, mem_read, mem_write;
  logic [2:0]  func3;
  logic [31:0] addr, wdata, rdata;
  logic        ready, err, stall;

  logic        z_ls_req, z_mem_read, z_mem_write;
  logic [2:0]  z_func3;
  logic [31:0] z_addr, z_wdata, z_rdata;
  logic        z_ready, z_err, z_stall;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYC(2), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .ls_req(ls_req), .mem_read(mem_read),
    .mem_write(mem_write), .func3(func3), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .stall(stall)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYC(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ls_req(z_ls_req), .mem_read(z_mem_read),
    .mem_write(z_mem_write), .func3(z_func3), .addr(z_addr), .wdata(z_wdata),
    .rdata(z_rdata), .ready(z_ready), .err(z_err), .stall(z_stall)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one request on the WAIT_CYC=2 instance; lat counts negedges from the
  // request cycle to the ready cycle (-1 on timeout).
  task automatic run_req(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int stalls, output logic e,
                         output logic wide, output logic [31:0] rv);
    int  n;
    logic got;
    mem_read = rd; mem_write = wr; func3 = f3; addr = a; wdata = d; ls_req = 1'b1;
    n = 0; got = 1'b0; stalls = 0; e = 1'bx;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (ready) begin
        got = 1'b1;
        e   = err;
      end else if (stall) begin
        stalls++;
      end
    end
    lat = got ? n : -1;
    @(posedge clk); #1;
    ls_req = 1'b0;
    @(negedge clk);
    wide = ready;
    rv   = rdata;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, stalls, gap, n;
    logic e, wide, seen;
    logic [31:0] rv;

    vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h10,   32'h11223344, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h13,   32'h00000080, 1'b0, 32'h00000000};
    vecs[2]  = '{1'b1, 1'b0, 3'b010, 32'h10,   32'h0,        1'b0, 32'h80223344};
    vecs[3]  = '{1'b1, 1'b0, 3'b000, 32'h13,   32'h0,        1'b0, 32'hFFFFFF80};
    vecs[4]  = '{1'b1, 1'b0, 3'b100, 32'h13,   32'h0,        1'b0, 32'h00000080};
    vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h12,   32'h0,        1'b0, 32'hFFFF8022};
    vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h12,   32'h0,        1'b0, 32'h00008022};
    vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h22,   32'h0,        1'b1, 32'h00008022};
    vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h20,   32'hCAFEF00D, 1'b0, 32'h00008022};
    vecs[9]  = '{1'b0, 1'b1, 3'b001, 32'h21,   32'h00001234, 1'b1, 32'h00008022};
    vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h20,   32'h0,        1'b0, 32'hCAFEF00D};
    vecs[11] = '{1'b1, 1'b1, 3'b010, 32'h20,   32'h00000000, 1'b1, 32'hCAFEF00D};
    vecs[12] = '{1'b0, 1'b0, 3'b010, 32'h20,   32'h0,        1'b1, 32'hCAFEF00D};
    vecs[13] = '{1'b1, 1'b0, 3'b011, 32'h20,   32'h0,        1'b1, 32'hCAFEF00D};
    vecs[14] = '{1'b0, 1'b1, 3'b100, 32'h21,   32'h00000000, 1'b1, 32'hCAFEF00D};
    vecs[15] = '{1'b1, 1'b0, 3'b010, 32'h1000, 32'h0,        1'b1, 32'hCAFEF00D};
    vecs[16] = '{1'b0, 1'b1, 3'b001, 32'h22,   32'h0000BEEF, 1'b0, 32'hCAFEF00D};
    vecs[17] = '{1'b0, 1'b1, 3'b000, 32'h20,   32'h0000007F, 1'b0, 32'hCAFEF00D};
    vecs[18] = '{1'b1, 1'b0, 3'b010, 32'h20,   32'h0,        1'b0, 32'hBEEFF07F};
    vecs[19] = '{1'b1, 1'b0, 3'b000, 32'h21,   32'h0,        1'b0, 32'hFFFFFFF0};
    vecs[20] = '{1'b1, 1'b0, 3'b000, 32'h20,   32'h0,        1'b0, 32'h0000007F};
    vecs[21] = '{1'b1, 1'b0, 3'b001, 32'h21,   32'h0,        1'b1, 32'h0000007F};
    vecs[22] = '{1'b0, 1'b1, 3'b010, 32'hFFC,  32'h01020304, 1'b0, 32'h0000007F};
    vecs[23] = '{1'b1, 1'b0, 3'b010, 32'hFFC,  32'h0,        1'b0, 32'h01020304};
    vecs[24] = '{1'b1, 1'b0, 3'b110, 32'h20,   32'h0,        1'b1, 32'h01020304};
    vecs[25] = '{1'b0, 1'b1, 3'b010, 32'h12,   32'h0,        1'b1, 32'h01020304};
    vecs[26] = '{1'b1, 1'b0, 3'b010, 32'h10,   32'h0,        1'b0, 32'h80223344};

    rst_n = 1'b0;
    ls_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0; func3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    z_ls_req = 1'b0; z_mem_read = 1'b0; z_mem_write = 1'b0; z_func3 = 3'd0; z_addr = 32'd0; z_wdata = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset rdata", rdata, 32'h0);
    check("reset ready", {31'd0, ready}, 32'd0);
    check("reset err",   {31'd0, err},   32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;

    run_req(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, stalls, e, wide, rv);
    check("first sw latency", 32'(lat), 32'd4);
    check("first sw stall cycles", 32'(stalls), 32'd3);
    check("first sw err", {31'd0, e}, 32'd0);
    check("first sw ready width", {31'd0, wide}, 32'd0);

    for (int i = 0; i < 27; i++) begin
      run_req(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].d, lat, stalls, e, wide, rv);
      check($sformatf("row%0d latency", i), 32'(lat), 32'd4);
      check($sformatf("row%0d err", i), {31'd0, e}, {31'd0, vecs[i].e});
      check($sformatf("row%0d rdata", i), rv, vecs[i].r);
      check($sformatf("row%0d ready width", i), {31'd0, wide}, 32'd0);
    end

    // Reset during WAIT must abort the store.
    run_req(1'b0, 1'b1, 3'b010, 32'h40, 32'h11111111, lat, stalls, e, wide, rv);
    run_req(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, lat, stalls, e, wide, rv);
    check("pre-abort lw", rv, 32'h11111111);
    mem_read = 1'b0; mem_write = 1'b1; func3 = 3'b010; addr = 32'h40; wdata = 32'hA5A5A5A5;
    ls_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort rdata cleared", rdata, 32'h0);
    ls_req = 1'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    check("abort no ready", {31'd0, seen}, 32'd0);
    @(posedge clk); #1;
    run_req(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, lat, stalls, e, wide, rv);
    check("abort lw latency", 32'(lat), 32'd4);
    check("abort lw keeps old word", rv, 32'h11111111);

    // WAIT_CYC=0: sw then lw with ls_req held throughout.
    @(posedge clk); #1;
    z_mem_read = 1'b0; z_mem_write = 1'b1; z_func3 = 3'b010; z_addr = 32'h40; z_wdata = 32'h5A5A1234;
    z_ls_req = 1'b1;
    n = 0; stalls = 0; seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (z_ready) seen = 1'b1;
      else if (z_stall) stalls++;
    end
    check("w0 sw latency", 32'(seen ? n : -1), 32'd2);
    check("w0 sw stall cycles", 32'(stalls), 32'd1);
    check("w0 sw err", {31'd0, z_err}, 32'd0);
    @(posedge clk); #1;
    z_mem_read = 1'b1; z_mem_write = 1'b0; z_wdata = 32'h0;
    gap = 0; seen = 1'b0;
    while (!seen && gap < 10) begin
      @(negedge clk);
      gap++;
      if (z_ready) seen = 1'b1;
    end
    check("w0 back-to-back spacing", 32'(seen ? gap : -1), 32'd3);
    check("w0 lw err", {31'd0, z_err}, 32'd0);
    @(posedge clk); #1;
    z_ls_req = 1'b0;
    @(negedge clk);
    check("w0 lw rdata", z_rdata, 32'h5A5A1234);
    check("w0 ready width", {31'd0, z_ready}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the load/store path of the single-issue core.
- Accepts a load or store request (lsReq with memRead/memWrite, funct3 size code, address, store data) and completes it after a programmable number of wait states.
- Returns a one-cycle ready strobe, sign- or zero-extended load data, and an error flag for illegal requests.
- Produces the pipeline stall signal consumed by the hazard logic.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; must be a power of two.
- WAIT_CYC, 2, wait states between acceptance and completion; range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- ls_req  in  1  load/store request, held by the core until ready.
- mem_read  in  1  request is a load.
- mem_write  in  1  request is a store.
- func3  in  3  size code, instr[14:12].
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- rdata  out  32  load result, extended to 32 bits.
- ready  out  1  one-cycle completion strobe.
- err  out  1  valid with ready; request was illegal.
- stall  out  1  combinational: ls_req && !ready.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rdata=0; ready=0; err=0; wait counter=0; request latch cleared.
  - Memory array is not reset.
- FSM states:
  - IDLE: when ls_req=1, latch mem_read, mem_write, func3, addr and wdata, and load the counter with WAIT_CYC. Go to WAIT if WAIT_CYC>0, otherwise go to ACK.
  - WAIT: decrement the counter each cycle. When it reaches 1, go to ACK. Total time in WAIT is WAIT_CYC cycles.
  - ACK: ready=1 for exactly this cycle; perform the store or load; go to DONE.
  - DONE: one bubble cycle so the core can drop or change ls_req; ready=0; go to IDLE.
- Latency: acceptance edge to ready = WAIT_CYC+1 cycles. Back-to-back requests are spaced WAIT_CYC+3 cycles.
- Inputs are sampled only at acceptance. Changes while in WAIT or ACK are ignored.
- Legality, evaluated on the latched request:
  - mem_read and mem_write both 1 or both 0 -> err.
  - Load func3 in {000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu}; any other -> err.
  - Store func3 in {000 sb, 001 sh, 010 sw}; any other -> err.
  - Misaligned -> err: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range -> err: (addr-BASE_ADDR) >= DEPTH_WORDS*4.
  - On err: ready still pulses, no memory write, rdata unchanged.
- Store in ACK:
  - Byte enables from func3 and addr[1:0]. sb writes one lane with wdata[7:0]; sh writes lanes {1,0} or {3,2} with wdata[15:0]; sw writes all four lanes.
  - Other lanes are unchanged.
- Load in ACK:
  - rdata registered at the ACK edge from the selected word and lane.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
  - rdata holds until the next successful load. Stores do not change it.
- Word index = (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2]. Upper bits are used only for the range check; there is no wrap-around.
- ls_req dropped by the core before ready: the request is still completed; ready and the store both happen.
- Reset asserted mid-WAIT or in ACK: the request is aborted, no write occurs, and state goes to IDLE. A store whose ACK edge coincides with the reset assertion is not written.
- WAIT_CYC=0: ACK follows IDLE directly and stall is high for exactly one cycle.

Decomposition:
- Shared package (riscv_pkg): funct3 load/store size encodings; typedef for the FSM state enum {IDLE, WAIT, ACK, DONE}; typedef for byte-enable [3:0].
- One sub-module, dmem_lane_ctrl, is combinational. Given func3, addr[1:0], wdata and the raw word, it produces byte enables, aligned store data, the extended load data, and the misalign flag.
- Storage is an inferred array inside dmem_responder.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> rdata=0, ready=0, err=0, stall=0. With WAIT_CYC=2, ls_req sw addr=0x10 wdata=0xDEADBEEF -> ready exactly 3 cycles after acceptance, err=0, stall high 3 cycles.
- Sized stores and loads:
  - sb 0x80 at addr 0x13 over word 0x11223344 -> word becomes 0x80223344.
  - lb 0x13 -> rdata=0xFFFFFF80.
  - lbu 0x13 -> 0x00000080.
  - lh 0x12 -> 0xFFFF8022.
- Misalignment: lw addr 0x22 -> ready with err=1, rdata unchanged. sh addr 0x21 -> err=1, memory word unchanged on readback.
- Illegal requests:
  - mem_read=mem_write=1 -> err=1.
  - Load func3=011 -> err=1.
  - Store func3=100 -> err=1.
  - addr=BASE+DEPTH_WORDS*4 -> err=1.
- Reset mid-operation: sw addr 0x40 wdata 0xA5A5A5A5, pulse rst_n low during WAIT -> no ready, state IDLE. A following lw 0x40 returns the prior contents.
- WAIT_CYC=0 back-to-back: sw then lw at the same address, ls_req held -> ready one cycle after each acceptance. Second acceptance occurs 3 cycles after the first; lw returns the stored value.
